// File: rtl/game_sequencer_if.sv
// ---------------------------------------------------------------------------
// game_sequencer_if
// Signal bundle between the ByteBasher game sequencer and the rest of the
// system (start button logic, sensor interface, LFSR, VGA, audio).
//
//   start        : single-cycle start pulse, synchronous to CLOCK_50
//   box_address  : sensor box ID (0 = none, 1..6 = box), asynchronous
//   lfsr_value   : free-running LFSR output used to pick targets
//   mif_select   : screen selector (0 lobby, 1..6 target, 7 game over)
//   score        : current score, 0..2047
//   time_left    : seconds remaining in the round
//   game_over    : high while the round is over
//   lobby_sound  : lobby tune request
//   play_sound   : hit sound request
//   hit_pulse    : one-cycle pulse on a correct strike
//   miss_pulse   : one-cycle pulse on a wrong strike or a target timeout
//
// Modports: slave = the sequencer, master = whoever drives its inputs.
// ---------------------------------------------------------------------------
interface game_sequencer_if;
  logic        start;
  logic [2:0]  box_address;
  logic [2:0]  lfsr_value;
  logic [2:0]  mif_select;
  logic [10:0] score;
  logic [6:0]  time_left;
  logic        game_over;
  logic        lobby_sound;
  logic        play_sound;
  logic        hit_pulse;
  logic        miss_pulse;

  modport slave (
    input  start, box_address, lfsr_value,
    output mif_select, score, time_left, game_over,
           lobby_sound, play_sound, hit_pulse, miss_pulse
  );

  modport master (
    output start, box_address, lfsr_value,
    input  mif_select, score, time_left, game_over,
           lobby_sound, play_sound, hit_pulse, miss_pulse
  );
endinterface

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// ByteBasher round controller: lobby -> timed play -> game over.
// Picks the active target box from the LFSR, qualifies strikes coming from
// the sensor interface, keeps the score and the countdown, selects the VGA
// screen and arbitrates the audio codec between lobby tune and hit sound.
//
// Ports:
//   CLOCK_50 : system clock
//   reset    : asynchronous, active-high; returns everything to lobby
//   bus      : game_sequencer_if.slave (start, box_address, lfsr_value in;
//              mif_select, score, time_left, game_over, lobby_sound,
//              play_sound, hit_pulse, miss_pulse out)
//
// Parameters:
//   TICK_DIV     : CLOCK_50 cycles per game-second
//   GAME_SECONDS : round length in seconds (1..127)
//   TARGET_TICKS : cycles a target stays up before it times out
//   SOUND_CYCLES : length of the play_sound stretch after the last hit
//
// Build option:
//   MISS_PENALTY_EN : when defined, every miss_pulse also decrements the
//                     score (saturating at 0) on the same edge.
// ---------------------------------------------------------------------------
module game_sequencer #(
  parameter int TICK_DIV     = 50_000_000,
  parameter int GAME_SECONDS = 60,
  parameter int TARGET_TICKS = 100_000_000,
  parameter int SOUND_CYCLES = 12_500_000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  game_sequencer_if.slave   bus
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WIN_W  = (TARGET_TICKS > 1) ? $clog2(TARGET_TICKS) : 1;
  localparam int SND_W  = $clog2(SOUND_CYCLES + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(TARGET_TICKS - 1);
  localparam logic [SND_W-1:0]  SND_LOAD  = SND_W'(SOUND_CYCLES);
  localparam logic [6:0]        SECS      = 7'(GAME_SECONDS);
  localparam logic [10:0]       SCORE_MAX = 11'd2047;

  typedef enum logic [1:0] {
    LOBBY = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [2:0]          s1, s2, s3;
  logic [2:0]          target, target_n;
  logic [10:0]         score, score_n;
  logic [6:0]          time_left, time_n;
  logic [TICK_W-1:0]   tick_cnt, tick_n;
  logic [WIN_W-1:0]    win_cnt, win_n;
  logic [SND_W-1:0]    snd_cnt, snd_n;
  logic                hit_q, hit_n;
  logic                miss_q, miss_n;

  logic                strike;
  logic                tick_now;
  logic                win_expired;

  // Saturating score step up.
  function automatic logic [10:0] sat_inc(input logic [10:0] s);
    return (s == SCORE_MAX) ? s : s + 11'd1;
  endfunction

`ifdef MISS_PENALTY_EN
  // Saturating score step down.
  function automatic logic [10:0] sat_dec(input logic [10:0] s);
    return (s == 11'd0) ? s : s - 11'd1;
  endfunction
`endif

  // Out-of-range LFSR values fall back to box 1; a repeat of the previous
  // target is bumped to the next box so the player always sees a change.
  function automatic logic [2:0] pick_target(input logic [2:0] lfsr,
                                             input logic [2:0] prev,
                                             input logic       has_prev);
    logic [2:0] t;
    t = ((lfsr >= 3'd1) && (lfsr <= 3'd6)) ? lfsr : 3'd1;
    if (has_prev && (t == prev))
      t = (prev == 3'd6) ? 3'd1 : prev + 3'd1;
    return t;
  endfunction

  // A strike is a fresh nonzero ID at the synchronizer output; a held ID
  // counts once, a direct jump between two IDs counts again.
  assign strike      = (s2 != 3'd0) && (s2 != s3);
  assign tick_now    = (tick_cnt == TICK_LAST);
  assign win_expired = (win_cnt == WIN_LAST);

  // ---- register stage: synchronizer, FSM state and game counters ----
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= LOBBY;
      s1        <= 3'd0;
      s2        <= 3'd0;
      s3        <= 3'd0;
      target    <= 3'd0;
      score     <= 11'd0;
      time_left <= SECS;
      tick_cnt  <= '0;
      win_cnt   <= '0;
      snd_cnt   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state     <= state_n;
      s1        <= bus.box_address;
      s2        <= s1;
      s3        <= s2;
      target    <= target_n;
      score     <= score_n;
      time_left <= time_n;
      tick_cnt  <= tick_n;
      win_cnt   <= win_n;
      snd_cnt   <= snd_n;
      hit_q     <= hit_n;
      miss_q    <= miss_n;
    end
  end

  // ---- next-state and screen/audio decode ----
  always_comb begin
    state_n         = state;
    target_n        = target;
    score_n         = score;
    time_n          = time_left;
    tick_n          = tick_cnt;
    win_n           = win_cnt;
    snd_n           = snd_cnt;
    hit_n           = 1'b0;
    miss_n          = 1'b0;
    bus.mif_select  = 3'd0;
    bus.game_over   = 1'b0;
    bus.lobby_sound = 1'b0;

    case (state)
      LOBBY: begin
        bus.lobby_sound = 1'b1;
        snd_n           = '0;
        if (bus.start) begin
          state_n  = PLAY;
          score_n  = 11'd0;
          time_n   = SECS;
          tick_n   = '0;
          win_n    = '0;
          target_n = pick_target(bus.lfsr_value, target, 1'b0);
        end
      end

      PLAY: begin
        bus.mif_select = target;
        tick_n         = tick_now ? '0 : tick_cnt + 1'b1;

        // A correct strike wins over a simultaneous window expiry.
        if (strike && (s2 == target)) begin
          hit_n    = 1'b1;
          score_n  = sat_inc(score);
          snd_n    = SND_LOAD;
          target_n = pick_target(bus.lfsr_value, target, 1'b1);
          win_n    = '0;
        end else begin
          if (snd_cnt != '0)
            snd_n = snd_cnt - 1'b1;
          win_n = win_cnt + 1'b1;
          if (strike)
            miss_n = 1'b1;
          if (win_expired) begin
            miss_n   = 1'b1;
            target_n = pick_target(bus.lfsr_value, target, 1'b1);
            win_n    = '0;
          end
`ifdef MISS_PENALTY_EN
          if (miss_n)
            score_n = sat_dec(score);
`endif
        end

        // Final tick: any hit above is already scored, sound is cut.
        if (tick_now) begin
          time_n = time_left - 7'd1;
          if (time_left == 7'd1) begin
            state_n = OVER;
            snd_n   = '0;
          end
        end
      end

      OVER: begin
        bus.mif_select = 3'd7;
        bus.game_over  = 1'b1;
        snd_n          = '0;
        if (bus.start) begin
          state_n = LOBBY;
          score_n = 11'd0;
          time_n  = SECS;
          tick_n  = '0;
          win_n   = '0;
        end
      end

      default: begin
        state_n = LOBBY;
      end
    endcase
  end

  // play_sound comes straight from the stretch counter, which is held at 0
  // outside PLAY, so it can never overlap lobby_sound.
  assign bus.play_sound = (snd_cnt != '0);
  assign bus.score      = score;
  assign bus.time_left  = time_left;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = miss_q;

endmodule
